// File: rtl/be_redirect_ctrl_if.sv
// be_redirect_ctrl_if: branch resolution inputs and redirect/flush outputs of be_redirect_ctrl
interface be_redirect_ctrl_if #(
  parameter int word_size_p     = 32,
  parameter int rob_idx_width_p = 5
);
  logic [rob_idx_width_p:0] rob_head_tag_i;
  logic                     br0_v_i, br1_v_i;
  logic                     br0_mispredict_i, br1_mispredict_i;
  logic [rob_idx_width_p:0] br0_tag_i, br1_tag_i;
  logic [word_size_p-1:0]   br0_target_i, br1_target_i;
  logic                     be_fe_mispredict_o;
  logic [word_size_p-1:0]   be_fe_redirected_pc_o;
  logic                     flush_o;
  logic [rob_idx_width_p:0] flush_tag_o;
  modport master (
    output rob_head_tag_i, br0_v_i, br1_v_i, br0_mispredict_i, br1_mispredict_i,
           br0_tag_i, br1_tag_i, br0_target_i, br1_target_i,
    input  be_fe_mispredict_o, be_fe_redirected_pc_o, flush_o, flush_tag_o
  );
  modport slave (
    input  rob_head_tag_i, br0_v_i, br1_v_i, br0_mispredict_i, br1_mispredict_i,
           br0_tag_i, br1_tag_i, br0_target_i, br1_target_i,
    output be_fe_mispredict_o, be_fe_redirected_pc_o, flush_o, flush_tag_o
  );
endinterface

// File: rtl/be_redirect_ctrl.sv
// be_redirect_ctrl: picks the oldest mispredict, pulses the fe redirect and holds a flush drain window.
// PJ_REDIRECT_PERF_EN adds saturating perf_redirects_o / perf_dropped_o counters.
module be_redirect_ctrl #(
  parameter int word_size_p     = 32,
  parameter int rob_idx_width_p = 5,
  parameter int drain_cycles_p  = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  be_redirect_ctrl_if.slave bus
`ifdef PJ_REDIRECT_PERF_EN
  ,
  output logic [31:0] perf_redirects_o,
  output logic [31:0] perf_dropped_o
`endif
);
  localparam int tw = rob_idx_width_p + 1;
  localparam int cw = $clog2(drain_cycles_p + 1);
  localparam logic [1:0] idle_s     = 2'd0;
  localparam logic [1:0] redirect_s = 2'd1;
  localparam logic [1:0] drain_s    = 2'd2;
  logic [1:0]             state;
  logic [cw-1:0]          cnt;
  logic [tw-1:0]          tag_q;
  logic [word_size_p-1:0] tgt_q;
  logic                   c0, c1, sel1, cv, acc;
  logic [tw-1:0]          a0, a1, aq, ca, ctag;
  logic [word_size_p-1:0] ctgt;
  // ages are modular distances from the ROB head, so tag wrap needs no special case
  always_comb begin
    c0   = bus.br0_v_i && bus.br0_mispredict_i;
    c1   = bus.br1_v_i && bus.br1_mispredict_i;
    a0   = bus.br0_tag_i - bus.rob_head_tag_i;
    a1   = bus.br1_tag_i - bus.rob_head_tag_i;
    aq   = tag_q - bus.rob_head_tag_i;
    sel1 = c1 && (!c0 || a1 < a0);
    cv   = c0 || c1;
    ca   = sel1 ? a1 : a0;
    ctag = sel1 ? bus.br1_tag_i : bus.br0_tag_i;
    ctgt = sel1 ? bus.br1_target_i : bus.br0_target_i;
    acc  = cv && (state == idle_s || ca < aq);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= idle_s;
      cnt   <= '0;
      tag_q <= '0;
      tgt_q <= '0;
    end else begin
      state <= acc ? redirect_s :
               state == redirect_s ? drain_s :
               (state == drain_s && cnt != cw'(1)) ? drain_s : idle_s;
      cnt   <= state == redirect_s ? cw'(drain_cycles_p) :
               state == drain_s ? cnt - cw'(1) : cnt;
      if (acc) begin
        tag_q <= ctag;
        tgt_q <= ctgt;
      end
    end
  assign bus.be_fe_mispredict_o    = state == redirect_s;
  assign bus.be_fe_redirected_pc_o = tgt_q;
  assign bus.flush_o               = state != idle_s;
  assign bus.flush_tag_o           = tag_q;
`ifdef PJ_REDIRECT_PERF_EN
  logic [1:0]  drop_inc;
  logic [32:0] drop_sum;
  always_comb begin
    drop_inc = {1'b0, c0 && c1} + {1'b0, cv && !acc};
    drop_sum = {1'b0, perf_dropped_o} + 33'(drop_inc);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      perf_redirects_o <= '0;
      perf_dropped_o   <= '0;
    end else begin
      if (state == redirect_s && perf_redirects_o != '1) perf_redirects_o <= perf_redirects_o + 32'd1;
      perf_dropped_o <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
`endif
  a_distinct_tags: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(c0 && c1 && bus.br0_tag_i == bus.br1_tag_i));
endmodule

// File: tb/tb_be_redirect_ctrl.sv
// tb_be_redirect_ctrl: scoreboard bench; a cycle-indexed redirect model predicts every cycle's outputs.
module tb_be_redirect_ctrl;
  localparam int D = 2;
  logic clk = 0;
  logic reset_n = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  be_redirect_ctrl_if #(.word_size_p(32), .rob_idx_width_p(5)) bus ();
`ifdef PJ_REDIRECT_PERF_EN
  logic [31:0] perf_r, perf_d;
`endif
  be_redirect_ctrl #(.word_size_p(32), .rob_idx_width_p(5), .drain_cycles_p(D)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
`ifdef PJ_REDIRECT_PERF_EN
    , .perf_redirects_o(perf_r), .perf_dropped_o(perf_d)
`endif
  );
  typedef struct {
    logic        pulse;
    logic        flush;
    logic [31:0] pc;
    logic [5:0]  tag;
    int          cyc;
  } exp_t;
  exp_t q[$];
  // model: a redirect accepted in cycle n pulses at n+1 and flushes through n+1+D
  int          cyc_n = 0;
  int          p = -100;
  logic [5:0]  lt = '0;
  logic [31:0] ltgt = '0;
  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pulse", e.cyc, 32'(bus.be_fe_mispredict_o), 32'(e.pulse));
      chk("flush", e.cyc, 32'(bus.flush_o), 32'(e.flush));
      chk("pc", e.cyc, bus.be_fe_redirected_pc_o, e.pc);
      chk("flush_tag", e.cyc, 32'(bus.flush_tag_o), 32'(e.tag));
    end
  task automatic step(input logic v0, m0, input logic [5:0] t0, input logic [31:0] g0,
                      input logic v1, m1, input logic [5:0] t1, input logic [31:0] g1,
                      input logic [5:0] head);
    exp_t e;
    logic [5:0] ages[2];
    int best;
    logic in_win;
    @(posedge clk);
    #1;
    reset_n = 1;
    bus.rob_head_tag_i = head;
    bus.br0_v_i = v0; bus.br0_mispredict_i = m0; bus.br0_tag_i = t0; bus.br0_target_i = g0;
    bus.br1_v_i = v1; bus.br1_mispredict_i = m1; bus.br1_tag_i = t1; bus.br1_target_i = g1;
    cyc_n++;
    in_win = cyc_n >= p && cyc_n <= p + D;
    e.pulse = cyc_n == p;
    e.flush = in_win;
    e.pc = ltgt;
    e.tag = lt;
    e.cyc = cyc_n;
    q.push_back(e);
    ages[0] = t0 - head;
    ages[1] = t1 - head;
    best = -1;
    if (v0 && m0) best = 0;
    if (v1 && m1 && (best < 0 || ages[1] < ages[0])) best = 1;
    if (best >= 0 && (!in_win || ages[best] < 6'(lt - head))) begin
      p = cyc_n + 1;
      lt = best ? t1 : t0;
      ltgt = best ? g1 : g0;
    end
  endtask
  task automatic idle(input int n, input logic [5:0] head);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, head);
  endtask
  task automatic do_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset_n = 0;
      bus.br0_v_i = 0; bus.br1_v_i = 0; bus.br0_mispredict_i = 0; bus.br1_mispredict_i = 0;
      cyc_n++;
      p = -100;
      lt = '0;
      ltgt = '0;
      e = '{pulse: 0, flush: 0, pc: 0, tag: 0, cyc: cyc_n};
      q.push_back(e);
    end
  endtask
  initial begin
    logic [5:0] head, t0, t1;
    bus.rob_head_tag_i = 0;
    bus.br0_v_i = 0; bus.br0_mispredict_i = 0; bus.br0_tag_i = 0; bus.br0_target_i = 0;
    bus.br1_v_i = 0; bus.br1_mispredict_i = 0; bus.br1_tag_i = 0; bus.br1_target_i = 0;
    do_reset(2);
    idle(1, 0);
    step(1, 1, 3, 32'h0120, 0, 0, 0, 0, 0);
    idle(5, 0);
    step(1, 1, 7, 32'h0700, 1, 1, 4, 32'h0400, 2);
    idle(5, 2);
    step(1, 1, 9, 32'h0900, 0, 0, 0, 0, 0);
    idle(1, 0);
    step(1, 1, 12, 32'h0c00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 6, 32'h0600, 0);
    idle(5, 0);
    step(1, 1, 1, 32'h1111, 0, 0, 0, 0, 62);
    step(1, 1, 63, 32'h6363, 0, 0, 0, 0, 62);
    step(1, 1, 62, 32'h6262, 0, 0, 0, 0, 62);
    idle(5, 62);
    step(1, 0, 5, 32'hdead, 1, 0, 9, 32'hbeef, 0);
    idle(3, 0);
    step(1, 1, 20, 32'h2020, 0, 0, 0, 0, 0);
    idle(2, 0);
    do_reset(2);
    idle(4, 0);
    head = 0;
    for (int i = 0; i < 600; i++) begin
      head = head + 6'($urandom_range(0, 1));
      t0 = head + 6'($urandom_range(0, 31));
      t1 = head + 6'($urandom_range(0, 31));
      if (t1 == t0) t1 = t0 + 6'd1;
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 2));
      else step($urandom_range(0, 1), $urandom_range(0, 3) == 0, t0, $urandom,
                $urandom_range(0, 1), $urandom_range(0, 3) == 0, t1, $urandom, head);
    end
    idle(4, head);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
